bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

BCD minutes:seconds countdown timer for the digital clock, the counting-down counterpart of the up-counting digit chain. Holds a loadable MM:SS value (00:00–59:59) and decrements it by one second per `sec_tick` strobe while running. Digits are propagated with a borrow chain: units to tens, and seconds to minutes. It signals expiry to the alarm/buzzer logic and drives the display mux with four BCD digits.

## Interface
- `AUTO_RELOAD`, default 0: when 1, expiry reloads the stored preset and keeps running; when 0, the timer stops at 00:00.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sec_tick` in 1: one-cycle strobe, one per second, from the prescaler.
- `load` in 1: one-cycle request to load the preset digits.
- `preset_min_t` in 3: preset minutes tens, 0–5.
- `preset_min_u` in 4: preset minutes units, 0–9.
- `preset_sec_t` in 3: preset seconds tens, 0–5.
- `preset_sec_u` in 4: preset seconds units, 0–9.
- `start` in 1: one-cycle request to run or resume.
- `pause` in 1: one-cycle request to hold.
- `min_t` out 3, `min_u` out 4, `sec_t` out 3, `sec_u` out 4: current count, registered.
- `running` out 1: high in RUN.
- `expired` out 1: high in EXPIRED.
- `done` out 1: one-cycle pulse on reaching 00:00.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values:
  - all count digits 0; preset register 00:00; state IDLE.
  - `running`, `expired`, `done`, `load_err` all 0.
- States and transitions:
  - IDLE: count static. `start` with count ≠ 00:00 → RUN. `start` with count = 00:00 is ignored.
  - RUN: each `sec_tick` decrements the count by 1 s. `pause` → PAUSE.
  - PAUSE: count static, ticks ignored. `start` → RUN.
  - EXPIRED: count held at 00:00. `start` is ignored. Only `load` or reset leaves this state.
- Load:
  - Accepted in any state.
  - Valid preset (units ≤ 9, tens ≤ 5): copies the digits to both the count and the preset register; state → IDLE.
  - Invalid preset: count, preset register and state are unchanged; `load_err` pulses.
- Priority within a cycle: `load` > `pause` > `start` > `sec_tick`.
  - `pause` with `sec_tick` in RUN: no decrement.
  - `start` with `sec_tick` in IDLE/PAUSE: state → RUN with no decrement that cycle.
- Decrement rules (borrow chain):
  - `sec_u` 0 → 9 with borrow to `sec_t`; otherwise −1.
  - `sec_t` (on borrow) 0 → 5 with borrow to `min_u`; otherwise −1.
  - `min_u` (on borrow) 0 → 9 with borrow to `min_t`; otherwise −1.
  - `min_t` (on borrow) decrements. It never underflows, because 00:00 is never decremented.
- Expiry (a tick in RUN with count = 00:01):
  - AUTO_RELOAD=0: count → 00:00, state → EXPIRED, `done` = 1 for one cycle.
  - AUTO_RELOAD=1: count → preset register, state stays RUN, `done` = 1 for one cycle.
  - AUTO_RELOAD=1 with preset 00:00: cannot reach RUN, because start at 00:00 is ignored.
- Digit outputs never take a non-BCD value. Minutes tens and seconds tens never exceed 5.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `sec_tick` sampled high in RUN at edge N → new count visible after edge N (1-cycle latency).
- `done` is high in the same cycle that 00:00, or the reloaded preset, first appears on the digits.
- `load` at edge N → new digits and IDLE after edge N. `load_err` is high for the cycle after edge N.
- `start`/`pause` at edge N → `running` updates after edge N.
- An asserting `rst_n` mid-count immediately forces all reset values, without waiting for a clock edge. Deassertion is taken as synchronous to `clk` (synchronized upstream).
- `sec_tick` wider than one cycle decrements once per cycle high. Upstream must guarantee single-cycle strobes.

## Test plan
- Load 01:00, start, apply 1 tick → 00:59. The borrow crosses from minutes to seconds; `running` = 1.
- Load 00:02, start, apply 2 ticks → 00:01, then 00:00. `done` pulses once with 00:00; `expired` = 1. Further ticks and `start` leave 00:00/EXPIRED.
- Load 00:05, start, apply 2 ticks, pause, apply 3 ticks, start, apply 1 tick → 00:03, held at 00:03, then 00:02. `pause` together with a tick gives no decrement.
- Load sec_u=10 (or min_t=6) while counting 12:34 in RUN → `load_err` pulses. Count stays 12:34, decrementing continues, state stays RUN.
- AUTO_RELOAD=1: load 00:03, start, apply 3 ticks → 00:02, 00:01, then 00:03 with `done` pulse. `running` stays 1.
- Load 59:59, start, apply 1 tick, assert `rst_n` low mid-cycle → 59:58, then asynchronously 00:00, IDLE, all flags 0. A subsequent start is ignored.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with a loadable preset, pause/resume and an expiry pulse.
// The count steps down with a units->tens and seconds->minutes borrow chain.
module bcd_countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       load,
    input  logic [2:0] preset_min_t,
    input  logic [3:0] preset_min_u,
    input  logic [2:0] preset_sec_t,
    input  logic [3:0] preset_sec_u,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Count and preset are packed as {min_t[2:0], min_u[3:0], sec_t[2:0], sec_u[3:0]}.
    localparam logic [13:0] COUNT_ZERO = 14'd0;
    localparam logic [13:0] COUNT_ONE  = 14'd1;

    function automatic logic bcd_valid(input logic [13:0] v);
        return (v[13:11] <= 3'd5) && (v[10:7] <= 4'd9) &&
               (v[6:4] <= 3'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [13:0] bcd_dec(input logic [13:0] v);
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        logic       borrow;
        mt = v[13:11];
        mu = v[10:7];
        st = v[6:4];
        su = v[3:0];
        if (su == 4'd0) begin
            su = 4'd9;
            borrow = 1'b1;
        end else begin
            su = su - 4'd1;
            borrow = 1'b0;
        end
        if (borrow) begin
            if (st == 3'd0) begin
                st = 3'd5;
            end else begin
                st = st - 3'd1;
                borrow = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            if (mu == 4'd0) begin
                mu = 4'd9;
            end else begin
                mu = mu - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            mt = mt - 3'd1;
        end else begin
            mt = mt;
        end
        return {mt, mu, st, su};
    endfunction

    state_t      state_r, state_s;
    logic [13:0] count_r, count_s;
    logic [13:0] preset_r, preset_s;
    logic        done_r, done_s;
    logic        load_err_r, load_err_s;
    logic        running_r, expired_r;
    logic [13:0] preset_in_s;

    assign preset_in_s = {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u};

    // Next-state logic: load > pause > start > sec_tick.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        preset_s   = preset_r;
        done_s     = 1'b0;
        load_err_s = 1'b0;
        if (load) begin
            if (bcd_valid(preset_in_s)) begin
                count_s  = preset_in_s;
                preset_s = preset_in_s;
                state_s  = ST_IDLE;
            end else begin
                load_err_s = 1'b1;
            end
        end else if (pause) begin
            if (state_r == ST_RUN) begin
                state_s = ST_PAUSE;
            end else begin
                state_s = state_r;
            end
        end else if (start) begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != COUNT_ZERO) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PAUSE: state_s = ST_RUN;
                default:  state_s = state_r;
            endcase
        end else if (sec_tick && (state_r == ST_RUN)) begin
            if (count_r == COUNT_ONE) begin
                done_s = 1'b1;
                if (AUTO_RELOAD) begin
                    count_s = preset_r;
                end else begin
                    count_s = COUNT_ZERO;
                    state_s = ST_EXPIRED;
                end
            end else if (count_r != COUNT_ZERO) begin
                count_s = bcd_dec(count_r);
            end else begin
                count_s = count_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, count, preset and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= COUNT_ZERO;
            preset_r   <= COUNT_ZERO;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
            running_r  <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            preset_r   <= preset_s;
            done_r     <= done_s;
            load_err_r <= load_err_s;
            running_r  <= (state_s == ST_RUN);
            expired_r  <= (state_s == ST_EXPIRED);
        end
    end

    assign min_t    = count_r[13:11];
    assign min_u    = count_r[10:7];
    assign sec_t    = count_r[6:4];
    assign sec_u    = count_r[3:0];
    assign running  = running_r;
    assign expired  = expired_r;
    assign done     = done_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: one instance without and one with auto-reload,
// both checked against a total-seconds reference model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [2:0] preset_min_t = 3'd0, preset_sec_t = 3'd0;
    logic [3:0] preset_min_u = 4'd0, preset_sec_u = 4'd0;

    logic [2:0] mt0, st0, mt1, st1;
    logic [3:0] mu0, su0, mu1, su1;
    logic       run0, exp0, done0, err0, run1, exp1, done1, err1;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .load(load),
        .preset_min_t(preset_min_t), .preset_min_u(preset_min_u),
        .preset_sec_t(preset_sec_t), .preset_sec_u(preset_sec_u),
        .start(start), .pause(pause),
        .min_t(mt0), .min_u(mu0), .sec_t(st0), .sec_u(su0),
        .running(run0), .expired(exp0), .done(done0), .load_err(err0));

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .load(load),
        .preset_min_t(preset_min_t), .preset_min_u(preset_min_u),
        .preset_sec_t(preset_sec_t), .preset_sec_u(preset_sec_u),
        .start(start), .pause(pause),
        .min_t(mt1), .min_u(mu1), .sec_t(st1), .sec_u(su1),
        .running(run1), .expired(exp1), .done(done1), .load_err(err1));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count as whole seconds; state 0 idle, 1 run, 2 pause, 3 expired.
    int m_sec[2], m_pre[2], m_st[2];
    bit m_done[2], m_err[2];

    logic [35:0] obs;
    assign obs = {mt0, mu0, st0, su0, run0, exp0, done0, err0,
                  mt1, mu1, st1, su1, run1, exp1, done1, err1};

    function automatic logic [17:0] exp_one(input int k);
        int s;
        logic [2:0] a;
        logic [3:0] b;
        logic [2:0] c;
        logic [3:0] d;
        s = m_sec[k];
        a = 3'(s / 600);
        b = 4'((s / 60) % 10);
        c = 3'((s % 60) / 10);
        d = 4'(s % 10);
        return {a, b, c, d, m_st[k] == 1, m_st[k] == 3, m_done[k], m_err[k]};
    endfunction

    function automatic logic [35:0] expv();
        return {exp_one(0), exp_one(1)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sec[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic set_preset(input int mt, input int mu, input int st, input int su);
        preset_min_t = 3'(mt); preset_min_u = 4'(mu);
        preset_sec_t = 3'(st); preset_sec_u = 4'(su);
    endtask

    // One clock: drive strobes, take the edge, then advance the model.
    task automatic drive(input bit l, input bit s, input bit p, input bit t);
        bit valid;
        load = l; start = s; pause = p; sec_tick = t;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; sec_tick = 1'b0;
        valid = (preset_min_t <= 5) && (preset_min_u <= 9) &&
                (preset_sec_t <= 5) && (preset_sec_u <= 9);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0; m_err[k] = 0;
            if (l) begin
                if (valid) begin
                    m_sec[k] = preset_min_t * 600 + preset_min_u * 60 +
                               preset_sec_t * 10 + preset_sec_u;
                    m_pre[k] = m_sec[k];
                    m_st[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else if (p) begin
                if (m_st[k] == 1) m_st[k] = 2;
            end else if (s) begin
                if ((m_st[k] == 0 && m_sec[k] != 0) || m_st[k] == 2) m_st[k] = 1;
            end else if (t && m_st[k] == 1) begin
                m_sec[k] = m_sec[k] - 1;
                if (m_sec[k] == 0) begin
                    m_done[k] = 1;
                    if (k == 1) m_sec[k] = m_pre[k];
                    else m_st[k] = 3;
                end
            end
        end
    endtask

    // L load, S start, P pause, T tick, B pause+tick, C start+tick, N idle.
    task automatic op(input byte c);
        case (c)
            "L": drive(1, 0, 0, 0);
            "S": drive(0, 1, 0, 0);
            "P": drive(0, 0, 1, 0);
            "T": drive(0, 0, 0, 1);
            "B": drive(0, 0, 1, 1);
            "C": drive(0, 1, 0, 1);
            default: drive(0, 0, 0, 0);
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_vec++;
        if (obs !== 36'd0) begin
            n_err++;
            $display("FAIL reset: got %h expected %h", obs, 36'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_borrow();
        string seq = "LST";
        set_preset(0, 1, 0, 0);
        for (int i = 0; i < seq.len(); i++) begin
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL borrow step %0d: got %h expected %h", i, obs, expv());
            end
        end
        n_vec++;
        if ({mt0, mu0, st0, su0, run0} !== {3'd0, 4'd0, 3'd5, 4'd9, 1'b1}) begin
            n_err++;
            $display("FAIL borrow_0059: got %h expected %h", {mt0, mu0, st0, su0, run0},
                     {3'd0, 4'd0, 3'd5, 4'd9, 1'b1});
        end
    endtask

    task automatic test_expire();
        string seq = "LSTTTTSNT";
        set_preset(0, 0, 0, 2);
        for (int i = 0; i < seq.len(); i++) begin
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL expire step %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_pause();
        string seq = "LSTTPTTBCTNB";
        set_preset(0, 0, 0, 5);
        for (int i = 0; i < seq.len(); i++) begin
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL pause step %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_load_err();
        string seq = "LSTTLTLT";
        for (int i = 0; i < seq.len(); i++) begin
            if (i == 0) set_preset(1, 2, 3, 4);
            else if (i == 4) set_preset(1, 2, 3, 10);
            else if (i == 6) set_preset(6, 0, 0, 0);
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL load_err step %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_autoreload();
        string seq = "LSTTTTT";
        set_preset(0, 0, 0, 3);
        for (int i = 0; i < seq.len(); i++) begin
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL autoreload step %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_async_reset();
        string seq = "LST";
        set_preset(5, 9, 5, 9);
        for (int i = 0; i < seq.len(); i++) begin
            op(seq[i]);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL async_reset step %0d: got %h expected %h", i, obs, expv());
            end
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (obs !== expv()) begin
            n_err++;
            $display("FAIL async_reset_mid: got %h expected %h", obs, expv());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        op("S");
        n_vec++;
        if (obs !== expv()) begin
            n_err++;
            $display("FAIL async_reset_start: got %h expected %h", obs, expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bit l, s, p, t;
            l = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 1) == 1);
            if (l) begin
                if ($urandom_range(0, 1) == 1)
                    set_preset(0, 0, $urandom_range(0, 1), $urandom_range(0, 9));
                else
                    set_preset($urandom_range(0, 6), $urandom_range(0, 10),
                               $urandom_range(0, 6), $urandom_range(0, 10));
            end
            drive(l, s, p, t);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_borrow();
        test_expire();
        test_pause();
        test_load_err();
        test_autoreload();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
